// File: rtl/fft4_inplace_ctrl_if.sv
// Sample-in / bin-out stream bundle for the 4-point in-place FFT sequencer.
interface fft4_inplace_ctrl_if #(
    parameter int unsigned DW = 8
);
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_re;
    logic [DW-1:0] in_im;
    logic          out_valid;
    logic          out_ready;
    logic          out_last;
    logic [DW-1:0] out_re;
    logic [DW-1:0] out_im;

    modport master (
        output in_valid, in_re, in_im, out_ready,
        input  in_ready, out_valid, out_re, out_im, out_last
    );

    modport slave (
        input  in_valid, in_re, in_im, out_ready,
        output in_ready, out_valid, out_re, out_im, out_last
    );
endinterface

// File: rtl/fft4_inplace_ctrl.sv
// Sequencer and 4-entry sample store for a 4-point radix-2 DIF FFT around an external butterfly.
// Define FFT4_BITREV_EN to emit bins in natural order; otherwise they leave in memory order.
module fft4_inplace_ctrl #(
    parameter int unsigned DW = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    fft4_inplace_ctrl_if.slave  strm,
    output logic                busy,
    output logic [DW-1:0]       bf_in0_re,
    output logic [DW-1:0]       bf_in0_im,
    output logic [DW-1:0]       bf_in1_re,
    output logic [DW-1:0]       bf_in1_im,
    output logic [DW-1:0]       bf_tw_re,
    output logic [DW-1:0]       bf_tw_im,
    input  logic [DW-1:0]       bf_out0_re,
    input  logic [DW-1:0]       bf_out0_im,
    input  logic [DW-1:0]       bf_out1_re,
    input  logic [DW-1:0]       bf_out1_im
);

    typedef enum logic [1:0] {StLoad, StBf, StOut} state_e;

    state_e        state_q, state_d;
    logic [1:0]    cnt_q, cnt_d;
    logic [DW-1:0] mem_re_q [4];
    logic [DW-1:0] mem_im_q [4];

    logic          ld_we;
    logic          bf_we;
    logic [1:0]    bf_a;
    logic [1:0]    bf_b;
    logic          tw_neg_j;
    logic [1:0]    rd_addr;

`ifdef FFT4_BITREV_EN
    assign rd_addr = {cnt_q[0], cnt_q[1]};
`else
    assign rd_addr = cnt_q;
`endif

    // Butterfly schedule: stage 1 pairs stride 2, stage 2 pairs stride 1.
    always_comb begin
        bf_a     = 2'd0;
        bf_b     = 2'd2;
        tw_neg_j = 1'b0;
        unique case (cnt_q)
            2'd0: begin bf_a = 2'd0; bf_b = 2'd2; end
            2'd1: begin bf_a = 2'd1; bf_b = 2'd3; tw_neg_j = 1'b1; end
            2'd2: begin bf_a = 2'd0; bf_b = 2'd1; end
            2'd3: begin bf_a = 2'd2; bf_b = 2'd3; end
            default: ;
        endcase
    end

    always_comb begin
        bf_in0_re = '0;
        bf_in0_im = '0;
        bf_in1_re = '0;
        bf_in1_im = '0;
        bf_tw_re  = '0;
        bf_tw_im  = '0;
        if (state_q == StBf) begin
            bf_in0_re = mem_re_q[bf_a];
            bf_in0_im = mem_im_q[bf_a];
            bf_in1_re = mem_re_q[bf_b];
            bf_in1_im = mem_im_q[bf_b];
            // -j is (0, -1); 1 is (1, 0); both exact in DW bits.
            bf_tw_re  = tw_neg_j ? '0 : DW'(1);
            bf_tw_im  = tw_neg_j ? '1 : '0;
        end
    end

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        ld_we          = 1'b0;
        bf_we          = 1'b0;
        busy           = 1'b0;
        strm.in_ready  = 1'b0;
        strm.out_valid = 1'b0;
        strm.out_last  = 1'b0;
        strm.out_re    = '0;
        strm.out_im    = '0;
        unique case (state_q)
            StLoad: begin
                strm.in_ready = 1'b1;
                if (strm.in_valid) begin
                    ld_we = 1'b1;
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) state_d = StBf;
                end
            end
            StBf: begin
                busy  = 1'b1;
                bf_we = 1'b1;
                cnt_d = cnt_q + 2'd1;
                if (cnt_q == 2'd3) state_d = StOut;
            end
            StOut: begin
                strm.out_valid = 1'b1;
                strm.out_last  = (cnt_q == 2'd3);
                strm.out_re    = mem_re_q[rd_addr];
                strm.out_im    = mem_im_q[rd_addr];
                if (strm.out_ready) begin
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) state_d = StLoad;
                end
            end
            default: begin
                state_d = StLoad;
                cnt_d   = 2'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StLoad;
            cnt_q   <= 2'd0;
            for (int i = 0; i < 4; i++) begin
                mem_re_q[i] <= '0;
                mem_im_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (ld_we) begin
                mem_re_q[cnt_q] <= strm.in_re;
                mem_im_q[cnt_q] <= strm.in_im;
            end
            if (bf_we) begin
                mem_re_q[bf_a] <= bf_out0_re;
                mem_im_q[bf_a] <= bf_out0_im;
                mem_re_q[bf_b] <= bf_out1_re;
                mem_im_q[bf_b] <= bf_out1_im;
            end
        end
    end

endmodule

// File: doc/fft4_inplace_ctrl.md
# fft4_inplace_ctrl

- Sequencer and sample store for the 4-point in-place radix-2 DIF FFT.
- Accepts four complex samples over a valid/ready stream into a 4-entry register file.
- Drives the combinational butterfly PE one butterfly per cycle over two stages, writes results back in place, then streams the four spectrum bins out.
- Sits directly upstream and downstream of the butterfly: feeds its inputs and twiddle, consumes its outputs.

## Interface
- DW, 8, sample component width; must equal butterfly width.
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input sample valid.
- in_ready  out  1  block can accept an input sample.
- in_re, in_im  in  DW  input sample, two's complement.
- out_valid  out  1  output bin valid.
- out_ready  in  1  downstream accepts output bin.
- out_re, out_im  out  DW  output bin.
- out_last  out  1  high with 4th output bin.
- busy  out  1  high in BF state.
- bf_in0_re, bf_in0_im, bf_in1_re, bf_in1_im  out  DW  butterfly operands.
- bf_tw_re, bf_tw_im  out  DW  butterfly twiddle.
- bf_out0_re, bf_out0_im, bf_out1_re, bf_out1_im  in  DW  butterfly results.

## Operation
- State machine: LOAD -> BF -> OUT -> LOAD.
- LOAD
  - in_ready=1.
  - Each beat (in_valid & in_ready) writes mem[cnt] and increments 2-bit cnt.
  - The beat with cnt=3 moves to BF with cnt=0.
- BF
  - Four cycles, step k=cnt.
  - k=0: pair (0,2), tw=(1,0).
  - k=1: pair (1,3), tw=(0,8'hFF), i.e. -j.
  - k=2: pair (0,1), tw=(1,0).
  - k=3: pair (2,3), tw=(1,0).
  - bf_in0=mem[a], bf_in1=mem[b] (combinational from mem).
  - At the edge: mem[a]<=bf_out0, mem[b]<=bf_out1.
  - After k=3, go to OUT with cnt=0.
- Outside BF, bf_in*/bf_tw* are driven to 0.
- OUT
  - out_valid=1; out_re/out_im combinational from mem[rd_addr(cnt)].
  - Each beat (out_valid & out_ready) increments cnt.
  - out_last=1 when cnt=3; the beat at cnt=3 returns to LOAD.
  - out_* hold stable while out_ready=0.
- Arithmetic is entirely in the butterfly; all sums and products wrap modulo 2^DW with no saturation or scaling.
- The twiddle ±j is exact in DW bits.

## Timing
- Reset values: state=LOAD, cnt=0, mem=0, in_ready=1, out_valid=0, out_last=0, busy=0, out_re=out_im=0, bf_*=0.
- Reset is asynchronous and may arrive in any state.
  - An interrupted frame is discarded.
  - No partial output is produced afterwards.
- Latency: last input beat accepted at edge E; BF writes at E+1..E+4; out_valid=1 from just after E+4.
  - Best case 4 cycles from last input accept to first output.
  - Frame throughput: 4 in + 4 BF + 4 out = 12 cycles minimum.
- in_ready=0 outside LOAD; in_valid is ignored there.
- in_valid may be low between LOAD beats; cnt holds.
- out_ready may stall indefinitely; no data loss.
- out_ready high while out_valid=0 has no effect.
- No overlap: a new frame is not accepted until the 4th output beat completes.
  - in_ready rises in the cycle after that beat.

## Configuration
- FFT4_BITREV_EN defined:
  - rd_addr(cnt) = bit-reverse(cnt), giving read order 0,2,1,3.
  - Bins leave in natural order X0,X1,X2,X3.
- Undefined:
  - rd_addr(cnt)=cnt.
  - Bins leave in memory (bit-reversed) order X0,X2,X1,X3.
- All other behaviour is identical.

## Test plan
- Impulse: in re=[1,0,0,0], im=0, out_ready=1 -> four bins re=1, im=0; out_last on 4th; out_valid 4 cycles after last input accept.
- Shifted impulse, FFT4_BITREV_EN defined: in re=[0,1,0,0] -> (1,0),(0,8'hFF),(8'hFF,0),(0,1).
  - Without the macro: (1,0),(8'hFF,0),(0,8'hFF),(0,1).
- DC wrap: in re=[64,64,64,64] -> all bins (0,0), since X0=256 wraps to 0; re=[1,1,1,1] -> (4,0),(0,0),(0,0),(0,0).
- Backpressure: out_ready=0 for 10 cycles at each output beat, and in_valid gapped between input beats -> identical bins; out_re/out_im stable while stalled; in_ready=0 throughout OUT.
- Reset mid-frame: assert rst_n=0 during BF step k=1 -> outputs return to reset values immediately; a following clean impulse frame yields four (1,0) bins.
- Back-to-back: two frames with in_valid=out_ready=1 continuously -> second frame's first input accepted in the cycle after the first frame's out_last beat; 12-cycle frame period.
